// File: rtl/tick_countdown_timer.sv
// Resynchronises a slow square wave into one-cycle ticks and runs a
// loadable, pausable countdown with an expiry pulse and sticky timeout.
module tick_countdown_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  input  logic             pause,
  input  logic             cancel,
  output logic             tick,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic             timed_out
);

  localparam int WARM = SYNC_STAGES + 1;
  localparam int WW   = $clog2(WARM + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [WW-1:0]          warm_q, warm_d;
  logic                   tick_q, tick_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic                   exp_q, exp_d;
  logic                   busy_q, busy_d;
  logic                   to_q, to_d;
  logic                   warm_done;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], slow_clk};
    edge_d    = sync_q[SYNC_STAGES-1];
    warm_done = (warm_q == WW'(WARM));
    warm_d    = warm_done ? warm_q : warm_q + 1'b1;
    // Suppress the false rise seen while the synchroniser fills after reset
    tick_d    = warm_done & sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    exp_d   = 1'b0;
    if (cancel) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else if (start) begin
      rem_d = load_val;
      if (load_val == '0) begin
        state_d = S_DONE;
        exp_d   = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_HOLD;
          end else if (tick_q) begin
            if (rem_q > CNT_W'(1)) begin
              rem_d = rem_q - 1'b1;
            end else if (rem_q == CNT_W'(1)) begin
              rem_d   = '0;
              exp_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_HOLD: begin
          if (!pause) state_d = S_RUN;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    to_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      warm_q  <= '0;
      tick_q  <= 1'b0;
      state_q <= S_IDLE;
      rem_q   <= '0;
      exp_q   <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      warm_q  <= warm_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  assign tick      = tick_q;
  assign remaining = rem_q;
  assign busy      = busy_q;
  assign expired   = exp_q;
  assign timed_out = to_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Bench for tick_countdown_timer: behavioural model checked every cycle
// over directed scenarios and randomized command traffic.
module tb_tick_countdown_timer;

  localparam int CNT_W = 8;
  localparam int VW    = CNT_W + 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             slow_clk = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic             pause = 1'b0;
  logic             cancel = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             expired;
  logic             timed_out;

  int n_chk = 0;
  int n_pass = 0;

  tick_countdown_timer #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .slow_clk(slow_clk),
    .start(start),
    .load_val(load_val),
    .pause(pause),
    .cancel(cancel),
    .tick(tick),
    .remaining(remaining),
    .busy(busy),
    .expired(expired),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  // slow square wave, period 10 clk, changes on falling edges
  bit slow_en = 1'b0;
  bit slow_lvl = 1'b0;
  int slow_cnt = 0;
  always @(negedge clk) begin
    if (slow_en) begin
      slow_cnt++;
      if (slow_cnt == 5) begin
        slow_cnt = 0;
        slow_clk = ~slow_clk;
      end
    end else begin
      slow_cnt = 0;
      slow_clk = slow_lvl;
    end
  end

  // reference model
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_rem = 0;
  bit    m_tick = 0;
  bit    m_exp = 0;
  bit    t_old;
  int    since = 0;
  bit    h1, h2, h3;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE;
      m_rem = 0;
      m_tick = 0;
      m_exp = 0;
      since = 0;
      h1 = 0;
      h2 = 0;
      h3 = 0;
    end else begin
      t_old = m_tick;
      m_exp = 0;
      if (cancel) begin
        m_mode = M_IDLE;
        m_rem = 0;
      end else if (start) begin
        m_rem = int'(load_val);
        if (load_val == 0) begin
          m_mode = M_DONE;
          m_exp = 1;
        end else m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (pause) m_mode = M_HOLD;
        else if (t_old) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_exp = 1;
            m_mode = M_DONE;
          end
        end
      end else if (m_mode == M_HOLD && !pause) begin
        m_mode = M_RUN;
      end
      // tick = slow sample two edges ago high, three edges ago low,
      // and never in the first three cycles after release
      since++;
      m_tick = h2 && !h3 && since >= 4;
      h3 = h2;
      h2 = h1;
      h1 = slow_clk;
    end
  end

  function automatic logic [VW-1:0] obs_v();
    return {tick, remaining, busy, expired, timed_out};
  endfunction

  function automatic logic [VW-1:0] exp_v();
    logic b, t;
    b = (m_mode == M_RUN) || (m_mode == M_HOLD);
    t = (m_mode == M_DONE);
    return {m_tick, CNT_W'(m_rem), b, m_exp, t};
  endfunction

  task automatic clr_cmds();
    start = 0;
    pause = 0;
    cancel = 0;
    load_val = '0;
  endtask

  task automatic test_reset();
    clr_cmds();
    slow_en = 0;
    slow_lvl = 1;
    reset = 0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (obs_v() !== '0) $display("FAIL reset_vals: dut=%h want=0", obs_v());
    else n_pass++;
    @(negedge clk);
    reset = 1;
    repeat (12) begin
      @(posedge clk); #1;
      n_chk++;
      if (obs_v() !== exp_v() || tick !== 1'b0)
        $display("FAIL warmup: dut=%h model=%h", obs_v(), exp_v());
      else n_pass++;
    end
  endtask

  task automatic test_tick();
    int nt = 0;
    slow_lvl = 0;
    repeat (8) @(negedge clk);
    slow_en = 1;
    repeat (60) begin
      @(posedge clk); #1;
      if (m_tick) nt++;
      n_chk++;
      if (obs_v() !== exp_v())
        $display("FAIL tick: dut=%h model=%h", obs_v(), exp_v());
      else n_pass++;
    end
    n_chk++;
    if (nt < 5) $display("FAIL tick_count: got %0d want >=5", nt);
    else n_pass++;
  endtask

  task automatic run_load(input logic [CNT_W-1:0] v);
    @(negedge clk);
    start = 1;
    load_val = v;
    @(negedge clk);
    start = 0;
  endtask

  task automatic test_count3();
    int cyc = 0;
    run_load(8'd3);
    while (!timed_out && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      n_chk++;
      if (obs_v() !== exp_v())
        $display("FAIL count3: dut=%h model=%h", obs_v(), exp_v());
      else n_pass++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if ({timed_out, busy, remaining} !== {2'b10, 8'd0})
      $display("FAIL count3_done: dut=%b%b/%0d want to=1 busy=0 rem=0",
               timed_out, busy, remaining);
    else n_pass++;
  endtask

  task automatic test_pause();
    int cyc = 0;
    run_load(8'd5);
    while (m_rem != 4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    while (!m_tick && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    pause = 1;
    repeat (25) begin
      @(posedge clk); #1;
      n_chk++;
      if (obs_v() !== exp_v())
        $display("FAIL pause: dut=%h model=%h", obs_v(), exp_v());
      else n_pass++;
    end
    n_chk++;
    if (remaining !== 8'd4 || busy !== 1'b1)
      $display("FAIL pause_hold: rem=%0d busy=%b want rem=4 busy=1", remaining, busy);
    else n_pass++;
    @(negedge clk);
    pause = 0;
    cyc = 0;
    while (!timed_out && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      n_chk++;
      if (obs_v() !== exp_v())
        $display("FAIL resume: dut=%h model=%h", obs_v(), exp_v());
      else n_pass++;
    end
    n_chk++;
    if (!timed_out) $display("FAIL resume_timeout: timed_out=%b want 1", timed_out);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    int cyc = 0;
    run_load(8'd5);
    while (m_rem != 2 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    run_load(8'd9);
    #1;
    n_chk++;
    if (obs_v() !== exp_v() || remaining !== 8'd9 || expired !== 1'b0)
      $display("FAIL retrigger: dut=%h model=%h", obs_v(), exp_v());
    else n_pass++;
    cyc = 0;
    while (!m_tick && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    cancel = 1;
    @(posedge clk); #1;
    n_chk++;
    if (obs_v() !== exp_v() || remaining !== '0 || busy !== 1'b0)
      $display("FAIL cancel: dut=%h model=%h", obs_v(), exp_v());
    else n_pass++;
    @(negedge clk);
    cancel = 0;
  endtask

  task automatic test_zero();
    run_load(8'd0);
    #1;
    n_chk++;
    if ({expired, timed_out, busy} !== 3'b110 || obs_v() !== exp_v())
      $display("FAIL zero_load: dut=%h model=%h", obs_v(), exp_v());
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({expired, timed_out} !== 2'b01)
      $display("FAIL zero_after: exp=%b to=%b want 0 1", expired, timed_out);
    else n_pass++;
  endtask

  task automatic test_random();
    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 15) == 0);
      load_val = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      cancel = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
      n_chk++;
      if (obs_v() !== exp_v())
        $display("FAIL random: dut=%h model=%h", obs_v(), exp_v());
      else n_pass++;
    end
    @(negedge clk);
    clr_cmds();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    run_load(8'd7);
    #1;
    n_chk++;
    if (remaining !== 8'd7 || obs_v() !== exp_v())
      $display("FAIL mid_load: dut=%h model=%h", obs_v(), exp_v());
    else n_pass++;
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    n_chk++;
    if (obs_v() !== '0) $display("FAIL mid_reset: dut=%h want=0", obs_v());
    else n_pass++;
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++;
      if (obs_v() !== '0) $display("FAIL mid_hold: dut=%h want=0", obs_v());
      else n_pass++;
    end
    @(negedge clk);
    reset = 1;
    repeat (20) begin
      @(posedge clk); #1;
      n_chk++;
      if (obs_v() !== exp_v())
        $display("FAIL post_reset: dut=%h model=%h", obs_v(), exp_v());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_count3();
    test_pause();
    test_retrigger();
    test_zero();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
